dist_mem_reader: RTL and testbench

Read-side controller for the distance memory (two true-dual-port RAMs holding four distances a/b/c/d per address). On start, it sweeps addresses 0..N-1 and drives the memory read-address ports. It absorbs the RAM read latency and serialises each 4-distance entry into a single valid/ready stream that feeds the sorter. The distance writer and this reader are never active on the same entries at once; the controller sequences them.

---
 rtl/dist_pkg.sv | 18 +
 rtl/dist_lane_serializer.sv | 48 ++++
 rtl/dist_mem_reader.sv | 116 +++++++++++
 tb/tb_dist_mem_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// Shared definitions for the distance-memory read path:
// the FSM state encoding and the lane geometry of one memory entry.
package dist_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      LOAD = 3'd2,
      SEND = 3'd3,
      FIN  = 3'd4
   } state_t;

   localparam int         LANES      = 4;
   localparam int         LANE_W     = 2;
   localparam logic [1:0] LANE_FIRST = 2'd0;
   localparam logic [1:0] LANE_LAST  = 2'd3;

endpackage

// File: rtl/dist_lane_serializer.sv
// Holds one 4-distance memory entry and presents it lane by lane
// on a valid/ready stream.
module dist_lane_serializer
   import dist_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              sending,
   input  logic              lastEntry,
   input  logic [WIDTH-1:0]  inA,
   input  logic [WIDTH-1:0]  inB,
   input  logic [WIDTH-1:0]  inC,
   input  logic [WIDTH-1:0]  inD,
   input  logic              ready,
   output logic [WIDTH-1:0]  distOut,
   output logic [LANE_W-1:0] lane,
   output logic              valid,
   output logic              last,
   output logic              entryDone
);

   logic [WIDTH-1:0] hold [LANES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) hold[i] <= '0;
         lane <= LANE_FIRST;
      end else if (load) begin
         hold[0] <= inA;
         hold[1] <= inB;
         hold[2] <= inC;
         hold[3] <= inD;
         lane    <= LANE_FIRST;
      end else if (valid && ready) begin
         lane <= lane + 2'd1;
      end
   end

   // Lane only advances on a handshake, so data/last stay stable under backpressure.
   assign valid     = sending;
   assign distOut   = hold[lane];
   assign last      = sending && (lane == LANE_LAST) && lastEntry;
   assign entryDone = valid && ready && (lane == LANE_LAST);

endmodule

// File: rtl/dist_mem_reader.sv
// Read-side controller for the distance memory: sweeps entries 0..N-1,
// waits out the RAM read latency and streams each entry as four distances.
module dist_mem_reader
   import dist_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int DEPTH      = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   num_entries,
   output logic [ADDR_WIDTH-1:0] readAddrReal,
   output logic [ADDR_WIDTH-1:0] readAddrImag,
   input  logic [WIDTH-1:0]      inaDist,
   input  logic [WIDTH-1:0]      inbDist,
   input  logic [WIDTH-1:0]      incDist,
   input  logic [WIDTH-1:0]      indDist,
   output logic [WIDTH-1:0]      dist_out,
   output logic [ADDR_WIDTH+1:0] dist_idx,
   output logic                  dist_valid,
   input  logic                  dist_ready,
   output logic                  dist_last,
   output logic                  busy,
   output logic                  done
);

   localparam int                    CNT_W     = $clog2(RD_LAT + 1) + 1;
   localparam logic [CNT_W-1:0]      ONE_CNT   = 1;
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = 1;
   localparam logic [ADDR_WIDTH:0]   ONE_N     = 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_N   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]      LAT_CNT   = CNT_W'(RD_LAT);

   state_t                  state;
   state_t                  stateNext;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [ADDR_WIDTH:0]     nEntries;
   logic [ADDR_WIDTH:0]     nClamped;
   logic [CNT_W-1:0]        waitCnt;
   logic                    lastEntry;
   logic                    entryDone;
   logic [LANE_W-1:0]       lane;

   assign nClamped  = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
   assign lastEntry = ({1'b0, addr} == (nEntries - ONE_N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = (nClamped == '0) ? FIN : WAIT;
         WAIT:    if (waitCnt == ONE_CNT) stateNext = LOAD;
         LOAD:    stateNext = SEND;
         SEND:    if (entryDone) stateNext = lastEntry ? FIN : WAIT;
         FIN:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // N is latched only from IDLE, so a start pulse while busy has no effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         nEntries <= '0;
         waitCnt  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               nEntries <= nClamped;
               addr     <= '0;
               waitCnt  <= LAT_CNT;
            end
            WAIT: waitCnt <= waitCnt - ONE_CNT;
            SEND: if (entryDone && !lastEntry) begin
               addr    <= addr + ONE_ADDR;
               waitCnt <= LAT_CNT;
            end
            default: ;
         endcase
      end
   end

   dist_lane_serializer #(
      .WIDTH(WIDTH)
   ) uSerializer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (state == LOAD),
      .sending   (state == SEND),
      .lastEntry (lastEntry),
      .inA       (inaDist),
      .inB       (inbDist),
      .inC       (incDist),
      .inD       (indDist),
      .ready     (dist_ready),
      .distOut   (dist_out),
      .lane      (lane),
      .valid     (dist_valid),
      .last      (dist_last),
      .entryDone (entryDone)
   );

   assign readAddrReal = addr;
   assign readAddrImag = addr;
   assign dist_idx     = {addr, lane};
   assign busy         = (state != IDLE);
   assign done         = (state == FIN);

endmodule

// File: tb/tb_dist_mem_reader.sv
// Directed bench for dist_mem_reader with a registered-read RAM model
// and a scoreboard of expected stream elements.
module tb_dist_mem_reader;

   localparam int WIDTH = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   num_entries = '0;
   logic [AW-1:0] readAddrReal, readAddrImag;
   logic [WIDTH-1:0] inaDist = '0, inbDist = '0, incDist = '0, indDist = '0;
   logic [WIDTH-1:0] dist_out;
   logic [AW+1:0] dist_idx;
   logic          dist_valid, dist_last, busy, done;
   logic          dist_ready = 1'b1;

   logic [WIDTH-1:0] memA [DEPTH];
   logic [WIDTH-1:0] memB [DEPTH];
   logic [WIDTH-1:0] memC [DEPTH];
   logic [WIDTH-1:0] memD [DEPTH];

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [AW+1:0]    idx;
      logic             last;
   } exp_t;

   exp_t sb[$];
   int   nAsserts = 0;
   int   nFails   = 0;

   always #5 clk = ~clk;

   // One-cycle registered-read RAMs
   always @(posedge clk) begin
      inaDist <= memA[readAddrReal];
      inbDist <= memB[readAddrImag];
      incDist <= memC[readAddrReal];
      indDist <= memD[readAddrImag];
   end

   dist_mem_reader #(
      .WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LAT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_entries(num_entries),
      .readAddrReal(readAddrReal), .readAddrImag(readAddrImag),
      .inaDist(inaDist), .inbDist(inbDist), .incDist(incDist), .indDist(indDist),
      .dist_out(dist_out), .dist_idx(dist_idx), .dist_valid(dist_valid),
      .dist_ready(dist_ready), .dist_last(dist_last), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic startSweep(input int n);
      int   nEff;
      exp_t e;
      nEff = (n > DEPTH) ? DEPTH : n;
      for (int k = 0; k < 4 * nEff; k++) begin
         e.data = WIDTH'(k + 1);
         e.idx  = (AW + 2)'(k);
         e.last = (k == 4 * nEff - 1);
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b1;
      num_entries = (AW + 1)'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      num_entries = '0;
   endtask

   // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
   task automatic runSweep(input int mode, input bit reStart, output int firstValid,
                           output int doneCycle, output int maxAddr, output int maxIdx);
      int   cyc;
      bit   stalled;
      logic [WIDTH-1:0] sOut;
      logic [AW+1:0]    sIdx;
      logic             sLast;
      exp_t e;
      cyc = 0; stalled = 0; sOut = '0; sIdx = '0; sLast = 1'b0;
      firstValid = -1; doneCycle = -1; maxAddr = 0; maxIdx = -1;
      while (cyc < 400 && doneCycle < 0) begin
         @(negedge clk);
         cyc++;
         dist_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         start = reStart && (cyc == 6);
         num_entries = (reStart && cyc == 6) ? (AW + 1)'(1) : '0;
         #1;
         check("addr_ports_equal", readAddrReal, readAddrImag);
         if (int'(readAddrReal) > maxAddr) maxAddr = int'(readAddrReal);
         if (stalled) begin
            check("valid_held_in_stall", dist_valid, 1);
            check("out_stable", dist_out, sOut);
            check("idx_stable", dist_idx, sIdx);
            check("last_stable", dist_last, sLast);
         end
         stalled = 0;
         if (dist_valid) begin
            if (firstValid < 0) firstValid = cyc;
            if (int'(dist_idx) > maxIdx) maxIdx = int'(dist_idx);
            if (dist_ready) begin
               check("element_expected", (sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("dist_out", dist_out, e.data);
                  check("dist_idx", dist_idx, e.idx);
                  check("dist_last", dist_last, e.last);
               end
            end else begin
               stalled = 1;
               sOut = dist_out; sIdx = dist_idx; sLast = dist_last;
            end
         end
         if (done) begin
            doneCycle = cyc;
            check("busy_during_done", busy, 1);
         end
      end
      start = 1'b0;
      num_entries = '0;
      check("done_within_budget", (doneCycle >= 0), 1);
      check("all_elements_seen", sb.size(), 0);
      @(negedge clk);
      #1;
      check("done_single_pulse", done, 0);
      check("busy_falls_after_done", busy, 0);
   endtask

   initial begin
      int  fv, dc, ma, mi, cnt;
      bit  found, sawDone;

      for (int i = 0; i < DEPTH; i++) begin
         memA[i] = WIDTH'(4 * i + 1);
         memB[i] = WIDTH'(4 * i + 2);
         memC[i] = WIDTH'(4 * i + 3);
         memD[i] = WIDTH'(4 * i + 4);
      end

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", dist_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", readAddrReal, 0);
      check("rst_out", dist_out, 0);
      check("rst_idx", dist_idx, 0);
      check("rst_last", dist_last, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Two entries, ready high
      startSweep(2);
      runSweep(0, 1'b0, fv, dc, ma, mi);
      check("first_valid_latency", fv, 3);
      check("n2_max_addr", ma, 1);
      check("n2_max_idx", mi, 7);

      // Same sweep with ready toggling
      startSweep(2);
      runSweep(1, 1'b0, fv, dc, ma, mi);
      check("stall_max_idx", mi, 7);

      // Zero entries
      startSweep(0);
      runSweep(0, 1'b0, fv, dc, ma, mi);
      check("n0_no_valid", fv, -1);
      check("n0_done_cycle", dc, 1);
      check("n0_addr_zero", ma, 0);

      // Clamp to DEPTH
      startSweep(12);
      runSweep(0, 1'b0, fv, dc, ma, mi);
      check("clamp_max_idx", mi, 31);
      check("clamp_max_addr", ma, 7);

      // Start re-pulsed mid-sweep is ignored
      startSweep(2);
      runSweep(0, 1'b1, fv, dc, ma, mi);
      check("restart_max_idx", mi, 7);
      check("restart_max_addr", ma, 1);

      // Reset during SEND of entry 1
      startSweep(2);
      dist_ready = 1'b1;
      found = 0; sawDone = 0; cnt = 0;
      while (!found && cnt < 100) begin
         @(negedge clk);
         cnt++;
         #1;
         if (done) sawDone = 1;
         if (dist_valid && dist_idx[AW+1:2] == 1) found = 1;
      end
      check("reached_entry1", found, 1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", dist_valid, 0);
      check("arst_out", dist_out, 0);
      check("arst_idx", dist_idx, 0);
      check("arst_last", dist_last, 0);
      check("arst_busy", busy, 0);
      check("arst_addr", readAddrReal, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         if (done) sawDone = 1;
      end
      check("arst_no_done", sawDone, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();

      // Restart after reset begins at entry 0
      startSweep(1);
      runSweep(0, 1'b0, fv, dc, ma, mi);
      check("post_rst_latency", fv, 3);
      check("post_rst_max_idx", mi, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
